sevseg_readback_decoder: RTL and testbench



---
 rtl/sevseg_pkg.sv | 33 +++
 rtl/sevseg_glyph_decode.sv | 37 +++
 rtl/sevseg_readback_decoder.sv | 168 ++++++++++++++++
 tb/tb_sevseg_readback_decoder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared constants for the seven-segment readback decoder.
//   - GLYPH[16]            canonical active-high segment patterns for hex 0..F
//                          (bit0 = segment a ... bit6 = segment g)
//   - ALT_GLYPH_7/9        alternate 7 (with segment f) and 9 (without segment d)
//   - ADDR_*               Avalon-MM word addresses
//   - STATUS_*             bit positions inside the STATUS word
//   - SEVSEG_ID            fixed value returned by the ID register
package sevseg_pkg;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] ALT_GLYPH_7 = 7'h27;
    localparam logic [6:0] ALT_GLYPH_9 = 7'h67;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_COUNT   = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_ID      = 2'd3;

    localparam int STATUS_NIBBLE_LSB  = 0;
    localparam int STATUS_VALID_BIT   = 4;
    localparam int STATUS_CHANGED_BIT = 5;
    localparam int STATUS_PATTERN_LSB = 8;

    localparam int CONTROL_IRQ_EN_BIT = 0;
    localparam int CONTROL_ENABLE_BIT = 1;

    localparam logic [31:0] SEVSEG_ID = 32'h5E65_0001;

endpackage

// File: rtl/sevseg_glyph_decode.sv
// sevseg_glyph_decode: combinational map from an active-high 7-segment
// pattern to the hex digit it shows.
//   pattern  in  7  active-high segments, bit0 = a ... bit6 = g
//   valid    out 1  pattern is a recognised hex glyph
//   nibble   out 4  decoded digit, 0 when not valid
// Optional macro SEVSEG_ALT_GLYPH_EN: also accept the alternate 7 (0x27)
// and 9 (0x67) glyphs some display drivers emit.
module sevseg_glyph_decode
    import sevseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        valid  = 1'b0;
        nibble = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPH[i]) begin
                valid  = 1'b1;
                nibble = 4'(i);
            end
        end
`ifdef SEVSEG_ALT_GLYPH_EN
        if (pattern == ALT_GLYPH_7) begin
            valid  = 1'b1;
            nibble = 4'd7;
        end
        if (pattern == ALT_GLYPH_9) begin
            valid  = 1'b1;
            nibble = 4'd9;
        end
`endif
    end

endmodule

// File: rtl/sevseg_readback_decoder.sv
// sevseg_readback_decoder: samples the segment bus driven to the display,
// debounces it, decodes the stable pattern back to a hex digit and exposes
// the result, a change counter and an interrupt on an Avalon-MM slave.
//   clk            in  1   single clock
//   reset          in  1   asynchronous, active-high
//   seg_in         in  7   segment bus (bit0 = a ... bit6 = g), async to clk
//   avs_address    in  2   word address: 0 STATUS, 1 COUNT, 2 CONTROL, 3 ID
//   avs_read       in  1   read strobe
//   avs_write      in  1   write strobe
//   avs_writedata  in  32  write data
//   avs_readdata   out 32  registered read data, latency 1, held between reads
//   irq            out 1   level interrupt = changed & irq_en
// Optional macro SEVSEG_ALT_GLYPH_EN (in sevseg_glyph_decode): also decode
// the alternate 7 / 9 glyphs.
module sevseg_readback_decoder
    import sevseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg_in,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    localparam int               FLT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(STABLE_CYCLES);

    logic [6:0]       seg_norm;
    logic [6:0]       sync_p0;
    logic [6:0]       sync_p1;
    logic [6:0]       s_prev;
    logic [FLT_W-1:0] flt_cnt;
    logic [FLT_W-1:0] flt_next;

    logic [6:0]       committed;
    logic [3:0]       nibble;
    logic             valid;
    logic             changed;
    logic [CNT_W-1:0] change_cnt;
    logic             irq_en;
    logic             enable;

    logic             commit;
    logic             dec_valid;
    logic [3:0]       dec_nibble;
    logic             wr_status;
    logic             wr_count;
    logic             wr_control;
    logic [31:0]      read_mux;
    logic             unused_wdata;

    assign seg_norm = ACTIVE_LOW ? ~seg_in : seg_in;

    // Run length of identical synchronized samples, saturating. Commit is
    // judged on the next value so that a clean step lands STABLE_CYCLES+2
    // edges after it is first sampled.
    always_comb begin
        if (sync_p1 != s_prev) begin
            flt_next = '0;
        end else if (flt_cnt == FLT_MAX) begin
            flt_next = FLT_MAX;
        end else begin
            flt_next = flt_cnt + FLT_W'(1);
        end
    end

    assign commit = enable && (flt_next == FLT_MAX) && (sync_p1 != committed);

    sevseg_glyph_decode u_decode (
        .pattern (sync_p1),
        .valid   (dec_valid),
        .nibble  (dec_nibble)
    );

    assign wr_status  = avs_write && (avs_address == ADDR_STATUS);
    assign wr_count   = avs_write && (avs_address == ADDR_COUNT);
    assign wr_control = avs_write && (avs_address == ADDR_CONTROL);

    // Only bit5 of STATUS and bits [1:0] of CONTROL are writable; any write
    // to COUNT clears it regardless of data.
    assign unused_wdata = ^{avs_writedata[31:6], avs_writedata[4:2]};

    always_comb begin
        read_mux = '0;
        case (avs_address)
            ADDR_STATUS: begin
                read_mux[STATUS_NIBBLE_LSB +: 4] = nibble;
                read_mux[STATUS_VALID_BIT]       = valid;
                read_mux[STATUS_CHANGED_BIT]     = changed;
                read_mux[STATUS_PATTERN_LSB +: 7] = committed;
            end
            ADDR_COUNT: begin
                read_mux[CNT_W-1:0] = change_cnt;
            end
            ADDR_CONTROL: begin
                read_mux[CONTROL_IRQ_EN_BIT] = irq_en;
                read_mux[CONTROL_ENABLE_BIT] = enable;
            end
            default: begin
                read_mux = SEVSEG_ID;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0      <= '0;
            sync_p1      <= '0;
            s_prev       <= '0;
            flt_cnt      <= '0;
            committed    <= '0;
            nibble       <= '0;
            valid        <= 1'b0;
            changed      <= 1'b0;
            change_cnt   <= '0;
            irq_en       <= 1'b0;
            enable       <= 1'b1;
            avs_readdata <= '0;
        end else begin
            // Stage p0/p1: two-flop synchronizer, then history for the filter
            sync_p0 <= seg_norm;
            sync_p1 <= sync_p0;
            s_prev  <= sync_p1;
            flt_cnt <= flt_next;

            // Commit stage: capture the stable pattern and its decode
            if (commit) begin
                committed <= sync_p1;
                nibble    <= dec_nibble;
                valid     <= dec_valid;
            end

            // A commit in the same cycle as a clear wins
            if (commit) begin
                changed <= 1'b1;
            end else if (wr_status && avs_writedata[STATUS_CHANGED_BIT]) begin
                changed <= 1'b0;
            end

            if (wr_count) begin
                change_cnt <= commit ? CNT_W'(1) : '0;
            end else if (commit) begin
                change_cnt <= change_cnt + CNT_W'(1);
            end

            if (wr_control) begin
                irq_en <= avs_writedata[CONTROL_IRQ_EN_BIT];
                enable <= avs_writedata[CONTROL_ENABLE_BIT];
            end

            // Read data reflects register state before this cycle's write/commit
            if (avs_read) begin
                avs_readdata <= read_mux;
            end
        end
    end

    assign irq = changed & irq_en;

endmodule

// File: tb/tb_sevseg_readback_decoder.sv
// tb_sevseg_readback_decoder: scoreboard bench. A reference model keeps the
// last STABLE_CYCLES+3 input samples and commits whenever the window that
// has reached the output side of the synchronizer is uniform and differs
// from the shown pattern. Two instances share every input: one with a
// 16-bit change counter and one with a 2-bit counter so that counter wrap
// is exercised within a short run.
module tb_sevseg_readback_decoder;

    localparam int S  = 4;
    localparam bit AL = 1'b1;

    localparam logic [6:0] REF_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg_in = 7'h7F;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] rdata16;
    logic [31:0] rdata2;
    logic        irq16;
    logic        irq2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sevseg_readback_decoder #(.STABLE_CYCLES(S), .CNT_W(16), .ACTIVE_LOW(AL)) dut (
        .clk(clk), .reset(reset), .seg_in(seg_in),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(rdata16), .irq(irq16)
    );

    sevseg_readback_decoder #(.STABLE_CYCLES(S), .CNT_W(2), .ACTIVE_LOW(AL)) dut_w (
        .clk(clk), .reset(reset), .seg_in(seg_in),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(rdata2), .irq(irq2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]  addr;
        logic [31:0] e16;
        logic [31:0] e2;
    } exp_t;

    exp_t        exp_q[$];
    logic [6:0]  hist[$];
    int          edge_k;
    int unsigned m_count;
    logic [6:0]  m_committed;
    bit          m_changed;
    bit          m_irq_en;
    bit          m_enable;

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (REF_GLYPH[i] == p) r = {1'b1, 4'(i)};
        end
`ifdef SEVSEG_ALT_GLYPH_EN
        if (p == 7'h27) r = 5'h17;
        if (p == 7'h67) r = 5'h19;
`endif
        return r;
    endfunction

    function automatic logic [31:0] exp_reg(input logic [1:0] a, input int unsigned mask);
        logic [4:0] d;
        d = ref_decode(m_committed);
        case (a)
            2'd0:    return {17'd0, m_committed, 2'b00, m_changed, d};
            2'd1:    return m_count & mask;
            2'd2:    return {30'd0, m_enable, m_irq_en};
            default: return 32'h5E65_0001;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            for (int i = 0; i < S + 3; i++) hist.push_back(7'h00);
            edge_k      = 0;
            m_count     = 0;
            m_committed = 7'h00;
            m_changed   = 1'b0;
            m_irq_en    = 1'b0;
            m_enable    = 1'b1;
            exp_q.delete();
        end else begin
            logic [6:0] p;
            bit         uniform;
            bit         do_commit;
            exp_t       e;
            edge_k++;
            hist.push_back(AL ? ~seg_in : seg_in);
            void'(hist.pop_front());
            p = hist[$-2];
            uniform = 1'b1;
            for (int m = 2; m <= S + 2; m++) begin
                if (hist[$-m] != p) uniform = 1'b0;
            end
            do_commit = m_enable && (edge_k >= S) && uniform && (p != m_committed);
            if (avs_read) begin
                e.addr = avs_address;
                e.e16  = exp_reg(avs_address, 32'h0000_FFFF);
                e.e2   = exp_reg(avs_address, 32'h0000_0003);
                exp_q.push_back(e);
            end
            if (avs_write && avs_address == 2'd0 && avs_writedata[5]) m_changed = 1'b0;
            if (avs_write && avs_address == 2'd1) m_count = 0;
            if (avs_write && avs_address == 2'd2) begin
                m_irq_en = avs_writedata[0];
                m_enable = avs_writedata[1];
            end
            if (do_commit) begin
                m_committed = p;
                m_changed   = 1'b1;
                m_count++;
            end
        end
    end

    // ---------------- monitor ----------------
    bit rd_pend;
    always @(posedge clk or posedge reset) begin
        if (reset) rd_pend <= 1'b0;
        else       rd_pend <= avs_read;
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("irq", {31'd0, irq16}, {31'd0, m_irq_en & m_changed});
            check("irq_w", {31'd0, irq2}, {31'd0, m_irq_en & m_changed});
            if (rd_pend) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard_underflow: read data presented with no expectation queued");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("rdata_a%0d", e.addr), rdata16, e.e16);
                    check($sformatf("rdata_w_a%0d", e.addr), rdata2, e.e2);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic rd(input logic [1:0] a);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic rw(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
        avs_read      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input logic [6:0] pat);
        seg_in = AL ? ~pat : pat;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_rdata", rdata16, 32'd0);
        check("reset_irq", {31'd0, irq16}, 32'd0);
        reset = 1'b0;
        rd(2'd3);
        rd(2'd0);
        rd(2'd2);

        // clean step to "2", read COUNT every cycle to pin the commit edge
        show(7'h5B);
        for (int i = 0; i < 10; i++) rd(2'd1);
        rd(2'd0);

        // short glitch of "1" must not commit; a long one must
        show(7'h06);
        idle(3);
        show(7'h5B);
        idle(8);
        rd(2'd1);
        show(7'h06);
        idle(10);
        rd(2'd1);

        // interrupt path, blank commit, clear, clear racing a commit
        wr(2'd2, 32'h3);
        show(7'h00);
        idle(10);
        rd(2'd0);
        wr(2'd0, 32'h20);
        rd(2'd0);
        show(7'h3F);
        idle(6);
        wr(2'd0, 32'h20);
        rd(2'd0);
        show(7'h06);
        idle(6);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1);

        // alternate glyph 7
        show(7'h27);
        idle(10);
        rd(2'd0);

        // enable=0 holds, re-enable commits
        wr(2'd2, 32'h1);
        show(7'h66);
        idle(10);
        rd(2'd0);
        rw(2'd2, 32'h3);
        rd(2'd0);
        rd(2'd1);

        // reset in the middle of filtering
        show(7'h4F);
        idle(3);
        reset = 1'b1;
        #1;
        check("midreset_rdata", rdata16, 32'd0);
        check("midreset_irq", {31'd0, irq16}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd(2'd0);
        rd(2'd1);
        rd(2'd2);
        rd(2'd3);
        idle(8);
        rd(2'd1);
        rw(2'd1, 32'd0);
        rd(2'd1);

        // randomized traffic
        for (int it = 0; it < 250; it++) begin
            int          sel;
            logic [6:0]  pat;
            logic [31:0] d;
            sel = $urandom_range(0, 19);
            if (sel < 16)       pat = REF_GLYPH[sel];
            else if (sel == 16) pat = 7'h00;
            else if (sel == 17) pat = 7'h27;
            else if (sel == 18) pat = 7'h67;
            else                pat = 7'($urandom);
            show(pat);
            repeat ($urandom_range(1, 9)) begin
                int op;
                op = $urandom_range(0, 11);
                d  = $urandom;
                if (op < 5)       rd(2'($urandom_range(0, 3)));
                else if (op == 5) wr(2'd0, d);
                else if (op == 6) wr(2'd1, d);
                else if (op == 7) begin
                    if ($urandom_range(0, 3) != 0) d[1] = 1'b1;
                    wr(2'd2, d);
                end
                else if (op == 8) begin
                    if ($urandom_range(0, 3) != 0) d[1] = 1'b1;
                    rw(2'($urandom_range(0, 3)), d);
                end
                else idle(1);
            end
        end

        wr(2'd2, 32'h3);
        for (int i = 0; i < 4; i++) rd(2'(i));
        idle(2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
